// File: rtl/ita_requant_pipe_pkg.sv
// ita_package: shared constants and types for the requantisation pipeline.
//   N         lane count
//   WO        signed accumulator width per lane
//   WI        output activation width per lane
//   EMS       multiplier / shift width (unsigned)
//   NumConsts number of loadable constant sets; CW is the set index width
package ita_package;

    localparam int unsigned N         = 16;
    localparam int unsigned WO        = 26;
    localparam int unsigned WI        = 8;
    localparam int unsigned EMS       = 8;
    localparam int unsigned NumConsts = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CW = idx_width(NumConsts);

    // One extra bit so the zero-extended multiplier keeps the product signed.
    localparam int unsigned RequantProdWidth = WO + EMS + 1;

    typedef enum logic {
        Signed   = 1'b0,
        Unsigned = 1'b1
    } requant_mode_e;

    typedef logic [EMS-1:0]                     requant_const_t;
    typedef logic signed [WI-1:0]               requant_t;
    typedef logic signed [RequantProdWidth-1:0] requant_prod_t;
    typedef logic [31:0]                        sat_count_t;

    typedef struct packed {
        requant_const_t mult;
        requant_const_t shift;
        requant_t       add;
        requant_mode_e  mode;
    } requant_cfg_t;

endpackage

// File: rtl/ita_requant_pipe_lane.sv
// ita_requant_lane: combinational arithmetic for one lane.
//   prod_i   signed product inp*mult (RequantProdWidth bits)
//   shift_i  right shift with round-half-up; shifts >= product width give 0
//   add_i    signed offset added after rounding
//   mode_i   Signed clamps to [-2^(WI-1), 2^(WI-1)-1], Unsigned to [0, 2^WI-1]
//   res_o    low WI bits of the clamped sum
//   sat_o    high when the clamp changed the value
module ita_requant_lane
    import ita_package::*;
(
    input  requant_prod_t  prod_i,
    input  requant_const_t shift_i,
    input  requant_t       add_i,
    input  requant_mode_e  mode_i,
    output logic [WI-1:0]  res_o,
    output logic           sat_o
);

    // One guard bit for the rounding add, one more for the offset add.
    localparam int unsigned RW = RequantProdWidth + 1;
    localparam int unsigned SW = RequantProdWidth + 2;

    localparam requant_const_t ShiftMax = EMS'(RequantProdWidth);
    localparam int SMin = -(2 ** (WI - 1));
    localparam int SMax = (2 ** (WI - 1)) - 1;
    localparam int UMax = (2 ** WI) - 1;

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] rnd;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] lo;
    logic signed [SW-1:0] hi;
    logic                 below;
    logic                 above;

    always_comb begin
        ext  = RW'(prod_i);
        half = '0;
        rnd  = '0;
        if (shift_i == '0) begin
            rnd = ext;
        end else if (shift_i < ShiftMax) begin
            // Arithmetic shift floors, so adding half first rounds half up.
            half = RW'(1) <<< (shift_i - requant_const_t'(1));
            rnd  = (ext + half) >>> shift_i;
        end

        sum = SW'(rnd) + SW'(add_i);

        lo = (mode_i == Unsigned) ? '0       : SW'(SMin);
        hi = (mode_i == Unsigned) ? SW'(UMax) : SW'(SMax);

        below = (sum < lo);
        above = (sum > hi);
        sat_o = below | above;

        if (below) begin
            res_o = WI'(lo);
        end else if (above) begin
            res_o = WI'(hi);
        end else begin
            res_o = WI'(sum);
        end
    end

endmodule

// File: rtl/ita_requant_pipe.sv
// ita_requant_pipe: two-stage, N-lane elastic requantiser.
//   clk_i / rst_i          clock, synchronous active-high reset
//   cfg_*                  write one constant set {mult, shift, add, mode} into the bank
//   inp_valid_i/inp_ready_o/inp_i/inp_sel_i   input beat and its constant-set select
//   oup_valid_o/oup_ready_i/oup_o             requantised output beat
//   sat_clr_i / sat_cnt_o  clear / read the saturated-lane counter
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// A producer holds valid and data stable until the transfer; ready may be
// combinational from downstream ready. Stage 1 holds products plus the beat's
// constants, stage 2 holds the finished lanes and their saturation flags.
module ita_requant_pipe
    import ita_package::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_we_i,
    input  logic [CW-1:0]      cfg_idx_i,
    input  logic [EMS-1:0]     cfg_mult_i,
    input  logic [EMS-1:0]     cfg_shift_i,
    input  logic [WI-1:0]      cfg_add_i,
    input  logic               cfg_mode_i,
    input  logic               inp_valid_i,
    output logic               inp_ready_o,
    input  logic [N*WO-1:0]    inp_i,
    input  logic [CW-1:0]      inp_sel_i,
    output logic               oup_valid_o,
    input  logic               oup_ready_i,
    output logic [N*WI-1:0]    oup_o,
    input  logic               sat_clr_i,
    output logic [31:0]        sat_cnt_o
);

    localparam int unsigned BW = $clog2(N + 1);

    requant_cfg_t          bank [NumConsts];
    requant_cfg_t          sel_cfg;
    logic signed [EMS:0]   mult_s;
    logic signed [WO-1:0]  lane_in [N];
    requant_prod_t         prod [N];

    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  hs;

    requant_prod_t         s1_prod [N];
    requant_const_t        s1_shift;
    requant_t              s1_add;
    requant_mode_e         s1_mode;

    logic [WI-1:0]         lane_res [N];
    logic [N-1:0]          lane_sat;
    logic [N*WI-1:0]       s2_data;
    logic [N-1:0]          s2_sat;

    sat_count_t            sat_cnt;
    logic [BW-1:0]         beat_sat;
    logic [32:0]           sat_sum;

    // Constant bank; a read in the same cycle as a write sees the old entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumConsts; i++) begin
                bank[i] <= '0;
            end
        end else if (cfg_we_i) begin
            bank[cfg_idx_i] <= '{mult:  cfg_mult_i,
                                 shift: cfg_shift_i,
                                 add:   requant_t'(cfg_add_i),
                                 mode:  requant_mode_e'(cfg_mode_i)};
        end
    end

    assign sel_cfg = bank[inp_sel_i];
    assign mult_s  = signed'({1'b0, sel_cfg.mult});

    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_in[i] = signed'(inp_i[i*WO +: WO]);
            prod[i]    = RequantProdWidth'(lane_in[i]) * RequantProdWidth'(mult_s);
        end
    end

    assign s2_adv      = !s2_valid || oup_ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign inp_ready_o = s1_adv;
    assign hs          = s2_valid && oup_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= inp_valid_i;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // Data registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (s1_adv && inp_valid_i) begin
            for (int i = 0; i < N; i++) begin
                s1_prod[i] <= prod[i];
            end
            s1_shift <= sel_cfg.shift;
            s1_add   <= sel_cfg.add;
            s1_mode  <= sel_cfg.mode;
        end
        if (s2_adv && s1_valid) begin
            for (int i = 0; i < N; i++) begin
                s2_data[i*WI +: WI] <= lane_res[i];
            end
            s2_sat <= lane_sat;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        ita_requant_lane u_lane (
            .prod_i  (s1_prod[g]),
            .shift_i (s1_shift),
            .add_i   (s1_add),
            .mode_i  (s1_mode),
            .res_o   (lane_res[g]),
            .sat_o   (lane_sat[g])
        );
    end

    assign beat_sat = BW'($countones(s2_sat));
    assign sat_sum  = 33'(sat_cnt) + 33'(beat_sat);

    // Clear takes priority over the accumulated value but still counts the
    // beat handed over in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sat_cnt <= '0;
        end else if (sat_clr_i) begin
            sat_cnt <= hs ? 32'(beat_sat) : '0;
        end else if (hs) begin
            sat_cnt <= sat_sum[32] ? '1 : sat_sum[31:0];
        end
    end

    assign oup_valid_o = s2_valid;
    assign oup_o       = s2_data;
    assign sat_cnt_o   = sat_cnt;

endmodule

// File: tb/tb_ita_requant_pipe.sv
// tb_ita_requant_pipe: directed and randomized stimulus against a behavioural
// requantisation model with an expected-beat queue.
module tb_ita_requant_pipe;
  import ita_package::*;

  localparam int OW = N * WI;
  localparam int IW = N * WO;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_i;
  logic           cfg_we_i;
  logic [CW-1:0]  cfg_idx_i;
  logic [EMS-1:0] cfg_mult_i;
  logic [EMS-1:0] cfg_shift_i;
  logic [WI-1:0]  cfg_add_i;
  logic           cfg_mode_i;
  logic           inp_valid_i;
  logic           inp_ready_o;
  logic [IW-1:0]  inp_i;
  logic [CW-1:0]  inp_sel_i;
  logic           oup_valid_o;
  logic           oup_ready_i;
  logic [OW-1:0]  oup_o;
  logic           sat_clr_i;
  logic [31:0]    sat_cnt_o;

  ita_requant_pipe dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_idx_i   (cfg_idx_i),
    .cfg_mult_i  (cfg_mult_i),
    .cfg_shift_i (cfg_shift_i),
    .cfg_add_i   (cfg_add_i),
    .cfg_mode_i  (cfg_mode_i),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .inp_i       (inp_i),
    .inp_sel_i   (inp_sel_i),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_o       (oup_o),
    .sat_clr_i   (sat_clr_i),
    .sat_cnt_o   (sat_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;

  int m_mult[NumConsts];
  int m_shift[NumConsts];
  int m_add[NumConsts];
  int m_mode[NumConsts];

  logic [OW-1:0] exp_q[$];
  int            exp_sat_q[$];
  longint        m_sat_cnt;

  int            cyc = 0;
  int            lat_watch = -1;
  bit            lat_arm = 0;
  bit            idle_chk = 0;
  bit            prev_stall = 0;
  logic [OW-1:0] prev_data;
  bit            rand_ready = 0;
  bit            const_en = 0;
  logic [OW-1:0] const_val;
  int            const_sat;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WI:0] ref_lane(input longint x, input int m, input int s,
                                           input int a, input int md);
    longint p, r, num, d, sum, lo, hi, c;
    logic   sat;
    logic [WI-1:0] v;
    p = x * m;
    if (s == 0) r = p;
    else if (s >= 35) r = 0;
    else begin
      d   = longint'(1) << s;
      num = p + d / 2;
      r   = num / d;
      if ((num % d) != 0 && num < 0) r = r - 1;   // floor, not truncate
    end
    sum = r + a;
    lo  = (md == 1) ? 0   : -128;
    hi  = (md == 1) ? 255 : 127;
    sat = (sum < lo) || (sum > hi);
    c   = (sum < lo) ? lo : (sum > hi) ? hi : sum;
    v   = WI'(c);
    return {sat, v};
  endfunction

  task automatic ref_beat(input logic [IW-1:0] beat, input int sel,
                          output logic [OW-1:0] val, output int nsat);
    logic signed [WO-1:0] lv;
    logic [WI:0] r;
    nsat = 0;
    val  = '0;
    for (int i = 0; i < N; i++) begin
      lv = beat[i*WO +: WO];
      r  = ref_lane(longint'(lv), m_mult[sel], m_shift[sel], m_add[sel], m_mode[sel]);
      val[i*WI +: WI] = r[WI-1:0];
      nsat += int'(r[WI]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NumConsts; i++) begin
      m_mult[i] = 0; m_shift[i] = 0; m_add[i] = 0; m_mode[i] = 0;
    end
    exp_q.delete();
    exp_sat_q.delete();
    m_sat_cnt  = 0;
    prev_stall = 0;
    lat_watch  = -1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(output bit acc);
    bit            hs;
    logic [OW-1:0] e;
    int            es;
    int            es_in;
    acc = 0;
    @(negedge clk);
    if (rst_i) begin
      @(posedge clk);
      #1;
      model_reset();
      idle_chk = 1;
    end else begin
      if (idle_chk) begin
        check("post_reset_valid", OW'(oup_valid_o), OW'(0));
        check("post_reset_ready", OW'(inp_ready_o), OW'(1));
        idle_chk = 0;
      end
      check("sat_cnt", OW'(sat_cnt_o), OW'(m_sat_cnt));
      if (prev_stall) begin
        check("stall_valid", OW'(oup_valid_o), OW'(1));
        check("stall_data", oup_o, prev_data);
      end
      if (lat_watch >= 0 && cyc == lat_watch + 1) check("latency_k1", OW'(oup_valid_o), OW'(0));
      if (lat_watch >= 0 && cyc == lat_watch + 2) begin
        check("latency_k2", OW'(oup_valid_o), OW'(1));
        lat_watch = -1;
      end
      acc = inp_valid_i && inp_ready_o;
      hs  = oup_valid_o && oup_ready_i;
      es  = 0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", OW'(oup_valid_o), OW'(0));
        end else begin
          e  = exp_q.pop_front();
          es = exp_sat_q.pop_front();
          check("oup_data", oup_o, e);
        end
      end
      if (sat_clr_i) m_sat_cnt = hs ? longint'(es) : 0;
      else if (hs) begin
        m_sat_cnt += es;
        if (m_sat_cnt > 64'hFFFF_FFFF) m_sat_cnt = 64'hFFFF_FFFF;
      end
      if (acc) begin
        if (lat_arm) begin lat_watch = cyc; lat_arm = 0; end
        if (const_en) begin
          exp_q.push_back(const_val);
          exp_sat_q.push_back(const_sat);
          const_en = 0;
        end else begin
          ref_beat(inp_i, int'(inp_sel_i), e, es_in);
          exp_q.push_back(e);
          exp_sat_q.push_back(es_in);
        end
      end
      if (cfg_we_i) begin
        m_mult[cfg_idx_i]  = int'(cfg_mult_i);
        m_shift[cfg_idx_i] = int'(cfg_shift_i);
        m_add[cfg_idx_i]   = int'($signed(cfg_add_i));
        m_mode[cfg_idx_i]  = int'(cfg_mode_i);
      end
      prev_stall = oup_valid_o && !oup_ready_i;
      prev_data  = oup_o;
      @(posedge clk);
      #1;
    end
    cyc++;
    if (rand_ready) oup_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic write_cfg(input int idx, input int mult, input int shift, input int add, input int mode);
    cfg_idx_i   = CW'(idx);
    cfg_mult_i  = EMS'(mult);
    cfg_shift_i = EMS'(shift);
    cfg_add_i   = WI'(add);
    cfg_mode_i  = 1'(mode);
    cfg_we_i    = 1;
    idle(1);
    cfg_we_i    = 0;
  endtask

  task automatic send(input logic [IW-1:0] data, input int sel);
    bit acc;
    int w;
    w = 0;
    inp_valid_i = 1;
    inp_i       = data;
    inp_sel_i   = CW'(sel);
    do begin
      cycle(acc);
      w++;
    end while (!acc && w < 60);
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $error("FAIL accept_timeout: observed ready=%0d after %0d cycles, required accept", inp_ready_o, w);
    end
    inp_valid_i = 0;
  endtask

  task automatic send_const(input logic [IW-1:0] data, input int sel,
                            input logic [OW-1:0] val, input int nsat);
    const_en  = 1;
    const_val = val;
    const_sat = nsat;
    send(data, sel);
  endtask

  task automatic drain();
    int w;
    w = 0;
    rand_ready  = 0;
    oup_ready_i = 1;
    while (exp_q.size() != 0 && w < 60) begin
      idle(1);
      w++;
    end
    check("drain_remaining", OW'(exp_q.size()), OW'(0));
  endtask

  function automatic logic [IW-1:0] fill(input int v);
    logic [IW-1:0] b;
    for (int i = 0; i < N; i++) b[i*WO +: WO] = WO'(v);
    return b;
  endfunction

  function automatic logic [IW-1:0] rand_beat();
    logic [IW-1:0]        b;
    logic signed [WO-1:0] lv;
    for (int i = 0; i < N; i++) begin
      lv = WO'($urandom);
      lv = lv >>> $urandom_range(0, 24);
      b[i*WO +: WO] = lv;
    end
    return b;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [OW-1:0] v127, v193, v80, v00, v17, v05, va9, v64;
    v127 = {N{8'd127}};
    v193 = {N{8'd193}};
    v80  = {N{8'h80}};
    v00  = {N{8'h00}};
    v17  = {N{8'd17}};
    v05  = {N{8'd5}};
    va9  = {N{8'hA9}};
    v64  = {N{8'd100}};

    rst_i = 1; cfg_we_i = 0; cfg_idx_i = '0; cfg_mult_i = '0; cfg_shift_i = '0;
    cfg_add_i = '0; cfg_mode_i = 0; inp_valid_i = 0; inp_i = '0; inp_sel_i = '0;
    oup_ready_i = 1; sat_clr_i = 0;
    @(posedge clk);
    #1;
    idle(3);
    rst_i = 0;

    // Constant sets for the directed arithmetic cases.
    write_cfg(0, 3, 4, 5, 0);
    write_cfg(1, 3, 4, 5, 1);
    write_cfg(2, 2, 0, -3, 0);
    write_cfg(3, 2, 40, 5, 0);
    write_cfg(4, 3, 4, 100, 0);

    lat_arm = 1;
    send_const(fill(1000), 0, v127, 16);
    send_const(fill(1000), 1, v193, 0);
    send_const(fill(-1000), 0, v80, 16);
    send_const(fill(-1000), 1, v00, 16);
    send_const(fill(10), 2, v17, 0);
    send_const(fill(10), 3, v05, 0);
    send_const(fill(-1000), 4, va9, 0);   // -187.5 rounds to -187, +100 = -87
    drain();

    // Saturation counter: clear, three fully saturated beats, then a clear
    // coinciding with the fourth handshake.
    sat_clr_i = 1; idle(1); sat_clr_i = 0;
    send_const(fill(1000), 0, v127, 16);
    send_const(fill(1000), 0, v127, 16);
    send_const(fill(1000), 0, v127, 16);
    drain();
    check("sat_cnt_48", OW'(sat_cnt_o), OW'(48));
    oup_ready_i = 0;
    send_const(fill(1000), 0, v127, 16);
    idle(2);
    sat_clr_i = 1; oup_ready_i = 1; idle(1); sat_clr_i = 0;
    check("sat_clr_with_hs", OW'(sat_cnt_o), OW'(16));
    sat_clr_i = 1; idle(1); sat_clr_i = 0;
    check("sat_clr_alone", OW'(sat_cnt_o), OW'(0));

    // Bank write in the same cycle as an accept selecting that set.
    cfg_idx_i = '0; cfg_mult_i = 8'd1; cfg_shift_i = 8'd0; cfg_add_i = '0; cfg_mode_i = 1;
    cfg_we_i  = 1;
    send_const(fill(1000), 0, v127, 16);
    cfg_we_i  = 0;
    send_const(fill(100), 0, v64, 0);
    drain();

    // Randomized constants and data under random back-pressure.
    for (int k = 4; k < NumConsts; k++) begin
      write_cfg(k, $urandom_range(0, 255), $urandom_range(0, 40),
                $urandom_range(0, 255) - 128, $urandom_range(0, 1));
    end
    rand_ready = 1;
    for (int k = 0; k < 20; k++) send(rand_beat(), $urandom_range(0, NumConsts - 1));
    drain();

    // Reset with two beats held in the pipeline.
    oup_ready_i = 0;
    send(rand_beat(), $urandom_range(0, NumConsts - 1));
    send(rand_beat(), $urandom_range(0, NumConsts - 1));
    rst_i = 1;
    idle(1);
    rst_i = 0;
    oup_ready_i = 1;
    idle(3);
    send(fill(1000), 0);   // bank was cleared, so mult is 0
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
